// File: rtl/router_switch_allocator.sv
// Switch allocator for one router: XY routing of FIFO head flits, per-output
// round-robin wormhole allocation, crossbar select codes and FIFO pop strobes.
module router_switch_allocator #(
    parameter logic [3:0]  LOCAL_X = 4'd2,
    parameter logic [3:0]  LOCAL_Y = 4'd1,
    parameter int unsigned FLIT_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] din_x,
    input  logic [FLIT_W-1:0] din_y,
    input  logic [FLIT_W-1:0] din_local,
    input  logic              empty_x,
    input  logic              empty_y,
    input  logic              empty_local,
    input  logic              ready_x,
    input  logic              ready_y,
    input  logic              ready_local,
    output logic              pop_x,
    output logic              pop_y,
    output logic              pop_local,
    output logic [1:0]        control_x,
    output logic [1:0]        control_y,
    output logic [1:0]        control_local,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned N_PORT = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned TYPE_HI = FLIT_W - 1;
    localparam int unsigned DSTX_HI = FLIT_W - 3;
    localparam int unsigned DSTY_HI = FLIT_W - 7;

    localparam logic [1:0] OUT_X     = 2'd0;
    localparam logic [1:0] OUT_Y     = 2'd1;
    localparam logic [1:0] OUT_LOCAL = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [FLIT_W-1:0] din_a [N_PORT];
    logic [N_PORT-1:0] valid;
    logic [N_PORT-1:0] ready_v;

    logic [0:0]        state_q [N_PORT];
    logic [0:0]        state_d [N_PORT];
    logic [1:0]        owner_q [N_PORT];
    logic [1:0]        owner_d [N_PORT];
    logic [1:0]        rr_q    [N_PORT];
    logic [1:0]        rr_d    [N_PORT];

    logic [N_PORT-1:0] is_head;
    logic [N_PORT-1:0] is_last;
    logic [N_PORT-1:0] owned;
    logic [N_PORT-1:0] orphan;
    logic [1:0]        route   [N_PORT];
    logic [N_PORT-1:0] cand    [N_PORT];

    logic [1:0]        ctrl    [N_PORT];
    logic [N_PORT-1:0] pop_v;
    logic [1:0]        scan;
    logic              found;

    logic [1:0]        n_orphan;
    logic [SUM_W-1:0]  drop_sum;
    logic [CNT_W-1:0]  drop_d;
    logic              unused_payload;

    assign din_a[0] = din_x;
    assign din_a[1] = din_y;
    assign din_a[2] = din_local;
    assign valid    = {~empty_local, ~empty_y, ~empty_x};
    assign ready_v  = {ready_local, ready_y, ready_x};
    assign unused_payload = ^{din_x[DSTY_HI-4:0], din_y[DSTY_HI-4:0], din_local[DSTY_HI-4:0]};

    // Head decode, XY route, ownership and allocation candidates
    always_comb begin
        is_head = '0;
        is_last = '0;
        owned   = '0;
        orphan  = '0;
        for (int i = 0; i < N_PORT; i++) begin
            route[i] = OUT_LOCAL;
            cand[i]  = '0;
        end
        for (int i = 0; i < N_PORT; i++) begin
            is_head[i] = ~din_a[i][TYPE_HI];
            is_last[i] = din_a[i][TYPE_HI] == din_a[i][TYPE_HI-1];
            if (din_a[i][DSTX_HI -: 4] != LOCAL_X) begin
                route[i] = OUT_X;
            end else if (din_a[i][DSTY_HI -: 4] != LOCAL_Y) begin
                route[i] = OUT_Y;
            end
            for (int o = 0; o < N_PORT; o++) begin
                if (state_q[o] == ST_BUSY && owner_q[o] == 2'(i)) begin
                    owned[i] = 1'b1;
                end
            end
            orphan[i] = valid[i] & ~owned[i] & ~is_head[i];
        end
        for (int o = 0; o < N_PORT; o++) begin
            for (int i = 0; i < N_PORT; i++) begin
                cand[o][i] = valid[i] & ~owned[i] & is_head[i] & (route[i] == 2'(o));
            end
        end
    end

    // Per-output next state, select codes and pop strobes
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        pop_v   = orphan;
        scan    = 2'd0;
        found   = 1'b0;
        for (int o = 0; o < N_PORT; o++) begin
            ctrl[o] = 2'b00;
        end
        for (int o = 0; o < N_PORT; o++) begin
            if (state_q[o] == ST_BUSY) begin
                if (valid[owner_q[o]] && ready_v[o]) begin
                    ctrl[o]             = owner_q[o] + 2'd1;
                    pop_v[owner_q[o]]   = 1'b1;
                    if (is_last[owner_q[o]]) begin
                        state_d[o] = ST_IDLE;
                    end
                end
            end else begin
                found = 1'b0;
                scan  = rr_q[o];
                for (int k = 0; k < N_PORT; k++) begin
                    scan = (scan == 2'd2) ? 2'd0 : scan + 2'd1;
                    if (!found && cand[o][scan]) begin
                        found      = 1'b1;
                        state_d[o] = ST_BUSY;
                        owner_d[o] = scan;
                        rr_d[o]    = scan;
                    end
                end
            end
        end
        // Reset silences the datapath even while orphans sit at FIFO heads
        if (rst_n) begin
            pop_v = '0;
            for (int o = 0; o < N_PORT; o++) begin
                ctrl[o] = 2'b00;
            end
        end
    end

    assign n_orphan = 2'($countones(orphan));
    assign drop_sum = SUM_W'(drop_cnt) + SUM_W'(n_orphan);
    assign drop_d   = (drop_sum > SUM_W'(255)) ? 8'hFF : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int o = 0; o < N_PORT; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= 2'd0;
                rr_q[o]    <= 2'd2;
            end
            drop_cnt <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            drop_cnt <= drop_d;
        end
    end

    assign pop_x         = pop_v[0];
    assign pop_y         = pop_v[1];
    assign pop_local     = pop_v[2];
    assign control_x     = ctrl[0];
    assign control_y     = ctrl[1];
    assign control_local = ctrl[2];

endmodule

// File: tb/tb_router_switch_allocator.sv
// Bench for router_switch_allocator: modelled input FIFOs, directed scenarios
// and randomized packets checked by a per-input expected-disposition scoreboard.
module tb_router_switch_allocator;

    localparam logic [3:0] LX = 4'd2;
    localparam logic [3:0] LY = 4'd1;
    localparam int DROP = 3;

    typedef struct {
        logic [39:0] f;
        int          d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] din_x, din_y, din_local;
    logic        empty_x, empty_y, empty_local;
    logic        ready_x, ready_y, ready_local;
    logic        pop_x, pop_y, pop_local;
    logic [1:0]  control_x, control_y, control_local;
    logic [7:0]  drop_cnt;

    logic [39:0] fq   [3][$];
    exp_t        expq [3][$];
    logic        pend [3];
    int          errors = 0;
    int          checks = 0;
    int          drops_exp = 0;

    router_switch_allocator #(.LOCAL_X(LX), .LOCAL_Y(LY), .FLIT_W(40)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_x(din_x), .din_y(din_y), .din_local(din_local),
        .empty_x(empty_x), .empty_y(empty_y), .empty_local(empty_local),
        .ready_x(ready_x), .ready_y(ready_y), .ready_local(ready_local),
        .pop_x(pop_x), .pop_y(pop_y), .pop_local(pop_local),
        .control_x(control_x), .control_y(control_y), .control_local(control_local),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int route_of(input logic [39:0] f);
        if (f[37:34] != LX) return 0;
        if (f[33:30] != LY) return 1;
        return 2;
    endfunction

    function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy);
        logic [39:0] f;
        f = {8'($urandom), $urandom};
        f[39:38] = t;
        f[37:34] = dx;
        f[33:30] = dy;
        return f;
    endfunction

    task automatic refresh();
        din_x       = (fq[0].size() > 0) ? fq[0][0] : 40'd0;
        din_y       = (fq[1].size() > 0) ? fq[1][0] : 40'd0;
        din_local   = (fq[2].size() > 0) ? fq[2][0] : 40'd0;
        empty_x     = (fq[0].size() == 0);
        empty_y     = (fq[1].size() == 0);
        empty_local = (fq[2].size() == 0);
    endtask

    task automatic push(input int i, input logic [39:0] f, input int d);
        exp_t e;
        e.f = f;
        e.d = d;
        fq[i].push_back(f);
        expq[i].push_back(e);
        if (d == DROP) drops_exp++;
    endtask

    // Whole packet: expected output is the XY route of its head
    task automatic push_pkt(input int i, input int len, input logic [3:0] dx, input logic [3:0] dy);
        logic [39:0] h;
        int d;
        h = mk((len == 1) ? 2'b00 : 2'b01, dx, dy);
        d = route_of(h);
        push(i, h, d);
        for (int k = 1; k < len; k++) begin
            push(i, mk((k == len - 1) ? 2'b11 : 2'b10, 4'($urandom), 4'($urandom)), d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d flits left after %0d cycles, required 0", fq[0].size() + fq[1].size() + fq[2].size(), n);
        end
    endtask

    // FIFO model: dequeue at the edge where the DUT held pop high
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        #1 refresh();
    end

    // Monitor: every pop must match the next expected flit and its disposition
    always @(negedge clk) begin
        logic [2:0]  mp;
        logic [1:0]  mc [3];
        logic [2:0]  mr;
        logic [39:0] dv [3];
        exp_t        e;
        int          d;
        mp = {pop_local, pop_y, pop_x};
        mr = {ready_local, ready_y, ready_x};
        mc[0] = control_x; mc[1] = control_y; mc[2] = control_local;
        dv[0] = din_x; dv[1] = din_y; dv[2] = din_local;
        for (int i = 0; i < 3; i++) begin
            pend[i] = mp[i];
            if (mp[i]) begin
                d = DROP;
                for (int o = 0; o < 3; o++) if (mc[o] == 2'(i + 1)) d = o;
                if (expq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop in%0d: got pop with din %0h, required no pop", i, dv[i]);
                end else begin
                    e = expq[i].pop_front();
                    chk($sformatf("flit_in%0d", i), dv[i], e.f);
                    chk($sformatf("dest_in%0d", i), 40'(d), 40'(e.d));
                end
            end
        end
        for (int o = 0; o < 3; o++) begin
            if (mc[o] != 2'b00) begin
                chk($sformatf("ready_out%0d", o), 40'(mr[o]), 40'd1);
                chk($sformatf("src_pop_out%0d", o), 40'(mp[mc[o] - 2'd1]), 40'd1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seq [5] = '{1, 1, 0, 1, 1};
        int xc_seq  [5] = '{0, 1, 0, 1, 1};
        int tie_seq [13] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
        int popc;
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        rst_n = 1'b1;
        ready_x = 1'b0; ready_y = 1'b0; ready_local = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl_x", 40'(control_x), 40'd0);
        chk("rst_ctrl_l", 40'(control_local), 40'd0);
        chk("rst_pops", 40'({pop_local, pop_y, pop_x}), 40'd0);
        chk("rst_drop", 40'(drop_cnt), 40'd0);
        tick();
        rst_n = 1'b0;

        // Single-flit packet on local to local
        ready_local = 1'b1;
        tick();
        push_pkt(2, 1, 4'd2, 4'd1);
        refresh();
        @(negedge clk);
        chk("single_grant_ctrl", 40'(control_local), 40'd0);
        chk("single_grant_pop", 40'(pop_local), 40'd0);
        @(negedge clk);
        chk("single_xfer_ctrl", 40'(control_local), 40'd3);
        chk("single_xfer_pop", 40'(pop_local), 40'd1);
        @(negedge clk);
        chk("single_after_ctrl", 40'(control_local), 40'd0);
        tick();

        // 3-flit packet on x to output x with ready_x stalling once
        push_pkt(0, 3, 4'd5, 4'd0);
        refresh();
        popc = 0;
        for (int k = 0; k < 5; k++) begin
            ready_x = rdy_seq[k][0];
            @(negedge clk);
            chk($sformatf("xpkt_ctrl_c%0d", k), 40'(control_x), 40'(xc_seq[k]));
            popc += int'(pop_x);
            tick();
        end
        @(negedge clk);
        chk("xpkt_idle_ctrl", 40'(control_x), 40'd0);
        chk("xpkt_pop_total", 40'(popc), 40'd3);
        tick();

        // Ties on output local: x and y each hold two 2-flit packets
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, 2, 4'd2, 4'd1);
            push_pkt(1, 2, 4'd2, 4'd1);
        end
        refresh();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk($sformatf("tie_ctrl_c%0d", k), 40'(control_local), 40'(tie_seq[k]));
        end
        tick();

        // Concurrent x->local and local->x packets
        ready_x = 1'b1;
        push_pkt(0, 3, 4'd2, 4'd1);
        push_pkt(2, 3, 4'd7, 4'd3);
        refresh();
        @(negedge clk);
        chk("conc_grant", 40'({control_x, control_local}), 40'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("conc_ctrl_l%0d", k), 40'(control_local), 40'd1);
            chk($sformatf("conc_ctrl_x%0d", k), 40'(control_x), 40'd3);
            chk($sformatf("conc_pops%0d", k), 40'({pop_local, pop_x}), 40'b11);
        end
        @(negedge clk);
        chk("conc_idle", 40'({control_x, control_local}), 40'd0);
        tick();

        // Orphan body flit on y
        push(1, mk(2'b10, 4'd0, 4'd0), DROP);
        refresh();
        @(negedge clk);
        chk("orphan_pop", 40'(pop_y), 40'd1);
        chk("orphan_ctrls", 40'({control_x, control_y, control_local}), 40'd0);
        chk("orphan_drop_before", 40'(drop_cnt), 40'd0);
        @(negedge clk);
        chk("orphan_drop_after", 40'(drop_cnt), 40'(drops_exp));
        tick();

        // Saturation: 300 orphans in total
        for (int k = 1; k < 300; k++) push(1, mk((k % 2 == 1) ? 2'b11 : 2'b10, 4'd3, 4'd3), DROP);
        refresh();
        wait_drain(400);
        @(negedge clk);
        chk("drop_saturate", 40'(drop_cnt), 40'((drops_exp > 255) ? 255 : drops_exp));
        tick();

        // Reset mid-packet: head and one body sent, two flits left behind
        push(0, mk(2'b01, 4'd5, 4'd0), 0);
        push(0, mk(2'b10, 4'd5, 4'd0), 0);
        push(0, mk(2'b10, 4'd5, 4'd0), DROP);
        push(0, mk(2'b11, 4'd5, 4'd0), DROP);
        refresh();
        @(negedge clk);
        chk("rstmid_grant", 40'(control_x), 40'd0);
        @(negedge clk);
        chk("rstmid_head", 40'(control_x), 40'd1);
        @(negedge clk);
        chk("rstmid_body", 40'(control_x), 40'd1);
        tick();
        rst_n = 1'b1;
        drops_exp = expq[0].size();
        @(negedge clk);
        chk("rstmid_ctrls", 40'({control_x, control_y, control_local}), 40'd0);
        chk("rstmid_pops", 40'({pop_local, pop_y, pop_x}), 40'd0);
        chk("rstmid_drop_clear", 40'(drop_cnt), 40'd0);
        tick();
        rst_n = 1'b0;
        wait_drain(20);
        @(negedge clk);
        chk("rstmid_drop_after", 40'(drop_cnt), 40'(drops_exp));
        tick();

        // Randomized packets, orphans and backpressure
        for (int c = 0; c < 200; c++) begin
            ready_x     = ($urandom_range(0, 3) != 0);
            ready_y     = ($urandom_range(0, 3) != 0);
            ready_local = ($urandom_range(0, 3) != 0);
            if (c < 150) begin
                for (int i = 0; i < 3; i++) begin
                    if ($urandom_range(0, 5) == 0)
                        push_pkt(i, $urandom_range(1, 4), 4'($urandom_range(1, 3)), 4'($urandom_range(0, 2)));
                    else if ($urandom_range(0, 19) == 0)
                        push(i, mk(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10, 4'd2, 4'd1), DROP);
                end
                refresh();
            end
            tick();
        end
        ready_x = 1'b1; ready_y = 1'b1; ready_local = 1'b1;
        wait_drain(3000);
        @(negedge clk);
        chk("rand_drop", 40'(drop_cnt), 40'((drops_exp > 255) ? 255 : drops_exp));
        chk("rand_left", 40'(expq[0].size() + expq[1].size() + expq[2].size()), 40'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
